// File: rtl/tftp_pkg.sv
// Shared types and constants for the TFTP read-request path.
package tftp_pkg;

  // Parser states, one per field of the request payload plus the response slot.
  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_LO,
    S_NAME,
    S_MODE,
    S_WAIT_END,
    S_DRAIN,
    S_RESPOND
  } state_t;

  // TFTP opcodes.
  localparam logic [15:0] OP_RRQ   = 16'd1;
  localparam logic [15:0] OP_WRQ   = 16'd2;
  localparam logic [15:0] OP_DATA  = 16'd3;
  localparam logic [15:0] OP_ACK   = 16'd4;
  localparam logic [15:0] OP_ERROR = 16'd5;

  // TFTP error codes.
  localparam logic [15:0] ERR_UNDEF      = 16'd0;
  localparam logic [15:0] ERR_NOT_FOUND  = 16'd1;
  localparam logic [15:0] ERR_ILLEGAL_OP = 16'd4;

endpackage

// File: rtl/tftp_rrq_controller.sv
// Per-frame parser for TFTP read requests: checks the opcode, gates the
// filename into the external CRC decoder, bounds the mode string and hands
// one serve/error response to the TX responder.
module tftp_rrq_controller
  import tftp_pkg::*;
#(
  parameter int          MAX_NAME   = 64,
  parameter int          MAX_MODE   = 16,
  parameter logic [15:0] RRQ_OPCODE = OP_RRQ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic        in_ready,
  output logic        fd_reset,
  output logic        fd_en,
  input  logic        fd_valid,
  input  logic [15:0] fd_mem_location,
  input  logic        fd_valid_port,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_ok,
  output logic [15:0] rsp_err_code,
  output logic [15:0] rsp_mem_location
);

  localparam int NW = $clog2(MAX_NAME + 1);
  localparam int MW = $clog2(MAX_MODE + 1);

  state_t      state_reg, state_next;
  logic [NW-1:0] name_cnt_reg, name_cnt_next;
  logic [MW-1:0] mode_cnt_reg, mode_cnt_next;
  logic [7:0]  op_hi_reg, op_hi_next;
  logic [15:0] err_reg, err_next;
  logic        mode_first_reg, mode_first_next;
  logic        name_match_reg, port_match_reg;
  logic [15:0] addr_reg;
  logic        rsp_ok_reg, rsp_ok_next;
  logic [15:0] rsp_err_code_reg, rsp_err_code_next;
  logic [15:0] rsp_mem_location_reg, rsp_mem_location_next;

  logic        accept;
  logic        do_resolve;
  logic        do_fail;
  logic        sel_name;
  logic        sel_port;
  logic [15:0] sel_addr;

  // The decoder verdict becomes final on the first MODE cycle; a terminator
  // arriving in that same cycle must see the live decoder outputs.
  assign sel_name = mode_first_reg ? fd_valid      : name_match_reg;
  assign sel_port = mode_first_reg ? fd_valid_port : port_match_reg;
  assign sel_addr = mode_first_reg ? fd_mem_location : addr_reg;

  assign rsp_ok           = rsp_ok_reg;
  assign rsp_err_code     = rsp_err_code_reg;
  assign rsp_mem_location = rsp_mem_location_reg;

  // Next-state, counter and handshake logic for the request parser.
  always_comb begin
    state_next            = state_reg;
    name_cnt_next         = name_cnt_reg;
    mode_cnt_next         = mode_cnt_reg;
    op_hi_next            = op_hi_reg;
    err_next              = err_reg;
    mode_first_next       = 1'b0;
    rsp_ok_next           = rsp_ok_reg;
    rsp_err_code_next     = rsp_err_code_reg;
    rsp_mem_location_next = rsp_mem_location_reg;
    in_ready              = (state_reg != S_RESPOND);
    fd_reset              = (state_reg != S_NAME);
    fd_en                 = 1'b0;
    rsp_valid             = (state_reg == S_RESPOND);
    accept                = in_valid & in_ready;
    do_resolve            = 1'b0;
    do_fail               = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (accept && in_sof) begin
          if (in_eof) begin
            do_fail = 1'b1;
          end else begin
            op_hi_next = in_data;
            state_next = S_OP_LO;
          end
        end
      end
      S_OP_LO: begin
        if (accept) begin
          if (in_eof) begin
            do_fail = 1'b1;
          end else if ({op_hi_reg, in_data} == RRQ_OPCODE) begin
            name_cnt_next = '0;
            state_next    = S_NAME;
          end else begin
            err_next   = ERR_ILLEGAL_OP;
            state_next = S_DRAIN;
          end
        end
      end
      S_NAME: begin
        fd_en = in_valid;
        if (accept) begin
          name_cnt_next = name_cnt_reg + NW'(1);
          if (in_eof) begin
            do_fail = 1'b1;
          end else if (in_data == 8'h00) begin
            mode_cnt_next   = '0;
            mode_first_next = 1'b1;
            state_next      = S_MODE;
          end else if (name_cnt_next == NW'(MAX_NAME)) begin
            err_next   = ERR_UNDEF;
            state_next = S_DRAIN;
          end
        end
      end
      S_MODE: begin
        if (accept) begin
          mode_cnt_next = mode_cnt_reg + MW'(1);
          if (in_data == 8'h00) begin
            if (in_eof) do_resolve = 1'b1;
            else        state_next = S_WAIT_END;
          end else if (in_eof) begin
            do_fail = 1'b1;
          end else if (mode_cnt_next == MW'(MAX_MODE)) begin
            err_next   = ERR_UNDEF;
            state_next = S_DRAIN;
          end
        end
      end
      S_WAIT_END: begin
        if (accept && in_eof) do_resolve = 1'b1;
      end
      S_DRAIN: begin
        if (accept && in_eof) begin
          rsp_ok_next       = 1'b0;
          rsp_err_code_next = err_reg;
          state_next        = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (do_resolve) begin
      if (!sel_port) begin
        state_next = S_IDLE;
      end else if (sel_name) begin
        rsp_ok_next           = 1'b1;
        rsp_mem_location_next = sel_addr;
        state_next            = S_RESPOND;
      end else begin
        rsp_ok_next       = 1'b0;
        rsp_err_code_next = ERR_NOT_FOUND;
        state_next        = S_RESPOND;
      end
    end

    if (do_fail) begin
      rsp_ok_next       = 1'b0;
      rsp_err_code_next = ERR_UNDEF;
      state_next        = S_RESPOND;
    end

    // A new frame start mid-frame abandons the old one silently.
    if (accept && in_sof && (state_reg == S_NAME || state_reg == S_MODE ||
                             state_reg == S_WAIT_END || state_reg == S_DRAIN)) begin
      fd_reset        = 1'b1;
      mode_first_next = 1'b0;
      if (in_eof) begin
        rsp_ok_next       = 1'b0;
        rsp_err_code_next = ERR_UNDEF;
        state_next        = S_RESPOND;
      end else begin
        op_hi_next = in_data;
        state_next = S_OP_LO;
      end
    end
  end

  // State, counters and the response holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg            <= S_IDLE;
      name_cnt_reg         <= '0;
      mode_cnt_reg         <= '0;
      op_hi_reg            <= '0;
      err_reg              <= '0;
      mode_first_reg       <= 1'b0;
      rsp_ok_reg           <= 1'b0;
      rsp_err_code_reg     <= '0;
      rsp_mem_location_reg <= '0;
    end else begin
      state_reg            <= state_next;
      name_cnt_reg         <= name_cnt_next;
      mode_cnt_reg         <= mode_cnt_next;
      op_hi_reg            <= op_hi_next;
      err_reg              <= err_next;
      mode_first_reg       <= mode_first_next;
      rsp_ok_reg           <= rsp_ok_next;
      rsp_err_code_reg     <= rsp_err_code_next;
      rsp_mem_location_reg <= rsp_mem_location_next;
    end
  end

  // Capture the decoder verdict once, on the first cycle after the name terminator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      name_match_reg <= 1'b0;
      port_match_reg <= 1'b0;
      addr_reg       <= '0;
    end else if (state_reg == S_MODE && mode_first_reg) begin
      name_match_reg <= fd_valid;
      port_match_reg <= fd_valid_port;
      addr_reg       <= fd_mem_location;
    end
  end

endmodule

// File: tb/tb_tftp_rrq_controller.sv
// Directed bench for the TFTP read-request controller.
module tb_tftp_rrq_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        in_ready;
  logic        fd_reset;
  logic        fd_en;
  logic        fd_valid = 1'b0;
  logic [15:0] fd_mem_location = 16'h0000;
  logic        fd_valid_port = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_ok;
  logic [15:0] rsp_err_code;
  logic [15:0] rsp_mem_location;

  int tests_run = 0;
  int tests_failed = 0;
  int fd_en_cnt;
  logic [7:0] frame[$];

  tftp_rrq_controller dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_sof           (in_sof),
    .in_eof           (in_eof),
    .in_ready         (in_ready),
    .fd_reset         (fd_reset),
    .fd_en            (fd_en),
    .fd_valid         (fd_valid),
    .fd_mem_location  (fd_mem_location),
    .fd_valid_port    (fd_valid_port),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_ok           (rsp_ok),
    .rsp_err_code     (rsp_err_code),
    .rsp_mem_location (rsp_mem_location)
  );

  always #5 clk = ~clk;

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) frame.push_back(s[i]);
  endtask

  task automatic build_rrq(input logic [7:0] op_lo, input string name);
    frame.delete();
    frame.push_back(8'h00);
    frame.push_back(op_lo);
    push_str(name);
    frame.push_back(8'h00);
    push_str("octet");
    frame.push_back(8'h00);
  endtask

  // One byte per clock; returns at posedge+1 after the last byte.
  task automatic send_frame(input bit with_eof);
    fd_en_cnt = 0;
    for (int i = 0; i < frame.size(); i++) begin
      @(negedge clk);
      in_data  = frame[i];
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_eof   = with_eof && (i == frame.size() - 1);
      #1;
      if (fd_en) fd_en_cnt++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    $display("[TB] frame sent: %0d bytes, fd_en cycles=%0d, rsp_valid=%0b ok=%0b err=%0d mem=%h",
             frame.size(), fd_en_cnt, rsp_valid, rsp_ok, rsp_err_code, rsp_mem_location);
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests_run++; if (fd_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_fd_reset got=%b exp=1", fd_reset); end
    tests_run++; if (fd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_fd_en got=%b exp=0", fd_en); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    tests_run++; if ({rsp_ok, rsp_err_code, rsp_mem_location} !== 33'd0) begin tests_failed++;
      $display("FAIL reset_rsp_fields got=%b/%h/%h exp=0/0000/0000", rsp_ok, rsp_err_code, rsp_mem_location); end
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_serve();
    fd_valid = 1'b1; fd_valid_port = 1'b1; fd_mem_location = 16'h0400;
    build_rrq(8'h01, "TinyCore-current.iso");
    send_frame(1'b1);
    tests_run++; if (fd_en_cnt !== 21) begin tests_failed++; $display("FAIL serve_fd_en_count got=%0d exp=21", fd_en_cnt); end
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL serve_rsp_valid got=%b exp=1", rsp_valid); end
    tests_run++; if (rsp_ok !== 1'b1) begin tests_failed++; $display("FAIL serve_rsp_ok got=%b exp=1", rsp_ok); end
    tests_run++; if (rsp_mem_location !== 16'h0400) begin tests_failed++; $display("FAIL serve_mem got=%h exp=0400", rsp_mem_location); end
    consume_rsp();
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL serve_single_rsp got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_not_found();
    fd_valid = 1'b0; fd_valid_port = 1'b1; fd_mem_location = 16'h0400;
    build_rrq(8'h01, "TinyCore-current.iso");
    send_frame(1'b1);
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL nf_rsp_valid got=%b exp=1", rsp_valid); end
    tests_run++; if (rsp_ok !== 1'b0) begin tests_failed++; $display("FAIL nf_rsp_ok got=%b exp=0", rsp_ok); end
    tests_run++; if (rsp_err_code !== 16'd1) begin tests_failed++; $display("FAIL nf_err_code got=%0d exp=1", rsp_err_code); end
    consume_rsp();
  endtask

  task automatic test_bad_opcode();
    fd_valid = 1'b1; fd_valid_port = 1'b1; fd_mem_location = 16'h0400;
    build_rrq(8'h02, "boot.img");
    send_frame(1'b1);
    tests_run++; if (fd_en_cnt !== 0) begin tests_failed++; $display("FAIL badop_fd_en_count got=%0d exp=0", fd_en_cnt); end
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL badop_rsp_valid got=%b exp=1", rsp_valid); end
    tests_run++; if ({rsp_ok, rsp_err_code} !== {1'b0, 16'd4}) begin tests_failed++;
      $display("FAIL badop_rsp got ok=%b err=%0d exp ok=0 err=4", rsp_ok, rsp_err_code); end
    consume_rsp();
  endtask

  task automatic test_short_frame();
    frame.delete();
    frame.push_back(8'h00);
    send_frame(1'b1);
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL short_rsp_valid got=%b exp=1", rsp_valid); end
    tests_run++; if ({rsp_ok, rsp_err_code} !== 17'd0) begin tests_failed++;
      $display("FAIL short_rsp got ok=%b err=%0d exp ok=0 err=0", rsp_ok, rsp_err_code); end
    consume_rsp();
  endtask

  task automatic test_long_name();
    frame.delete();
    frame.push_back(8'h00);
    frame.push_back(8'h01);
    for (int i = 0; i < 70; i++) frame.push_back(8'h41);
    send_frame(1'b1);
    tests_run++; if (fd_en_cnt !== 64) begin tests_failed++; $display("FAIL long_fd_en_count got=%0d exp=64", fd_en_cnt); end
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL long_rsp_valid got=%b exp=1", rsp_valid); end
    tests_run++; if ({rsp_ok, rsp_err_code} !== 17'd0) begin tests_failed++;
      $display("FAIL long_rsp got ok=%b err=%0d exp ok=0 err=0", rsp_ok, rsp_err_code); end
    consume_rsp();
  endtask

  task automatic test_port_drop();
    fd_valid = 1'b1; fd_valid_port = 1'b0; fd_mem_location = 16'h0400;
    build_rrq(8'h01, "TinyCore-current.iso");
    send_frame(1'b1);
    for (int c = 0; c < 3; c++) begin
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_rsp_valid cycle=%0d got=%b exp=0", c, rsp_valid); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL drop_in_ready cycle=%0d got=%b exp=1", c, in_ready); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    fd_valid = 1'b1; fd_valid_port = 1'b1; fd_mem_location = 16'h0400;
    build_rrq(8'h01, "TinyCore-current.iso");
    send_frame(1'b1);
    in_data = 8'h00; in_valid = 1'b1; in_sof = 1'b1;
    fd_mem_location = 16'hBEEF; fd_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, in_ready); end
      tests_run++; if ({rsp_valid, rsp_ok, rsp_mem_location} !== {1'b1, 1'b1, 16'h0400}) begin tests_failed++;
        $display("FAIL bp_rsp_stable cycle=%0d got v=%b ok=%b mem=%h exp v=1 ok=1 mem=0400", c, rsp_valid, rsp_ok, rsp_mem_location); end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    consume_rsp();
    tests_run++; if ({rsp_valid, in_ready} !== 2'b01) begin tests_failed++;
      $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, in_ready); end
    $display("[TB] backpressure transaction released");
  endtask

  task automatic test_reset_mid_name();
    fd_valid = 1'b1; fd_valid_port = 1'b1; fd_mem_location = 16'h0400;
    frame.delete();
    frame.push_back(8'h00);
    frame.push_back(8'h01);
    push_str("Tiny");
    send_frame(1'b0);
    in_data = 8'h43; in_valid = 1'b1;
    #1;
    tests_run++; if (fd_en !== 1'b1) begin tests_failed++; $display("FAIL midname_fd_en got=%b exp=1", fd_en); end
    reset = 1'b0;
    #1;
    tests_run++; if ({in_ready, fd_reset, fd_en, rsp_valid} !== 4'b1100) begin tests_failed++;
      $display("FAIL midreset_ctrl got rdy=%b fdr=%b fde=%b v=%b exp 1/1/0/0", in_ready, fd_reset, fd_en, rsp_valid); end
    tests_run++; if ({rsp_ok, rsp_err_code, rsp_mem_location} !== 33'd0) begin tests_failed++;
      $display("FAIL midreset_rsp got=%b/%h/%h exp=0/0000/0000", rsp_ok, rsp_err_code, rsp_mem_location); end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fd_mem_location = 16'h0812;
    build_rrq(8'h01, "a.bin");
    send_frame(1'b1);
    tests_run++; if ({rsp_valid, rsp_ok, rsp_mem_location} !== {1'b1, 1'b1, 16'h0812}) begin tests_failed++;
      $display("FAIL postreset_rsp got v=%b ok=%b mem=%h exp v=1 ok=1 mem=0812", rsp_valid, rsp_ok, rsp_mem_location); end
    tests_run++; if (fd_en_cnt !== 6) begin tests_failed++; $display("FAIL postreset_fd_en_count got=%0d exp=6", fd_en_cnt); end
    consume_rsp();
  endtask

  initial begin
    test_reset();
    test_serve();
    test_not_found();
    test_bad_opcode();
    test_short_frame();
    test_long_name();
    test_port_drop();
    test_back_to_back();
    test_reset_mid_name();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
